// File: rtl/e300_arty_devkit_chip.sv
// E300 Arty dev-kit chip top: reset merge and synchronizers, boot banner over
// UART TX (8N1), boot-done flag and status LEDs.
`timescale 1ns/1ps

module e300_arty_devkit_chip #(
    parameter int unsigned UART_DIV   = 579,
    parameter int unsigned BOOT_DELAY = 16,
    parameter int unsigned HB_DIV     = 100000
) (
    input  logic       cpu_clock,
    input  logic       cpu_rst_n,
    input  logic       jtag_rst_n,
    output logic       uart_tx,
    output logic       boot_done,
    output logic [3:0] led
);

    localparam int unsigned DIV_W = $clog2(UART_DIV);
    localparam int unsigned DLY_W = $clog2(BOOT_DELAY + 1);
    localparam int unsigned HB_W  = $clog2(HB_DIV);
    localparam logic [3:0]  LAST_IDX = 4'd13;
    localparam logic [3:0]  STOP_BIT = 4'd9;
    localparam logic [3:0]  LAST_DATA_BIT = 4'd8;

    typedef enum logic [1:0] {
        ST_DELAY = 2'd0,
        ST_SEND  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Banner ROM: "E300 BOOT OK\r\n"
    function automatic logic [7:0] banner_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    banner_byte = 8'h45;
            4'd1:    banner_byte = 8'h33;
            4'd2:    banner_byte = 8'h30;
            4'd3:    banner_byte = 8'h30;
            4'd4:    banner_byte = 8'h20;
            4'd5:    banner_byte = 8'h42;
            4'd6:    banner_byte = 8'h4F;
            4'd7:    banner_byte = 8'h4F;
            4'd8:    banner_byte = 8'h54;
            4'd9:    banner_byte = 8'h20;
            4'd10:   banner_byte = 8'h4F;
            4'd11:   banner_byte = 8'h4B;
            4'd12:   banner_byte = 8'h0D;
            4'd13:   banner_byte = 8'h0A;
            default: banner_byte = 8'h00;
        endcase
    endfunction

    logic             w_rst_n_raw;
    logic             w_rst_n_int;
    logic [7:0]       w_byte;
    logic [1:0]       r_rst_sync;
    logic [1:0]       r_jtag_sync;

    state_t           r_state;
    logic [DLY_W-1:0] r_dly;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit;
    logic [3:0]       r_idx;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic [HB_W-1:0]  r_hb;
    logic             r_hb_led;

    assign w_rst_n_raw = cpu_rst_n & jtag_rst_n;
    assign w_rst_n_int = r_rst_sync[1];
    assign w_byte      = banner_byte(r_idx);

    // Merged reset: asynchronous assertion, two-flop synchronized release
    always_ff @(posedge cpu_clock or negedge w_rst_n_raw) begin
        if (!w_rst_n_raw) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // JTAG-domain release indicator, reset only by jtag_rst_n
    always_ff @(posedge cpu_clock or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            r_jtag_sync <= 2'b00;
        end else begin
            r_jtag_sync <= {r_jtag_sync[0], 1'b1};
        end
    end

    // Boot FSM: delay, then back-to-back banner frames, then terminal done
    always_ff @(posedge cpu_clock or negedge w_rst_n_int) begin
        if (!w_rst_n_int) begin
            r_state <= ST_DELAY;
            r_dly   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_DELAY: begin
                    if (r_dly == DLY_W'(BOOT_DELAY - 1)) begin
                        r_state <= ST_SEND;
                        r_idx   <= '0;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                ST_SEND: begin
                    if (r_div == DIV_W'(UART_DIV - 1)) begin
                        r_div <= '0;
                        if (r_bit == STOP_BIT) begin
                            if (r_idx == LAST_IDX) begin
                                r_state <= ST_DONE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                // Next start bit follows the stop bit directly
                                r_idx <= r_idx + 4'd1;
                                r_bit <= '0;
                                r_tx  <= 1'b0;
                            end
                        end else begin
                            // r_bit 0..7 moves onto data bit r_bit; 8 moves onto stop
                            r_bit <= r_bit + 4'd1;
                            r_tx  <= (r_bit == LAST_DATA_BIT) ? 1'b1 : w_byte[r_bit[2:0]];
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_DELAY;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Heartbeat: toggle the LED every HB_DIV cycles
    always_ff @(posedge cpu_clock or negedge w_rst_n_int) begin
        if (!w_rst_n_int) begin
            r_hb     <= '0;
            r_hb_led <= 1'b0;
        end else if (r_hb == HB_W'(HB_DIV - 1)) begin
            r_hb     <= '0;
            r_hb_led <= ~r_hb_led;
        end else begin
            r_hb <= r_hb + HB_W'(1);
        end
    end

    assign uart_tx   = r_tx;
    assign boot_done = r_done;
    assign led       = {r_done, r_busy, r_jtag_sync[1], r_hb_led};

endmodule

// File: tb/tb_e300_arty_devkit_chip.sv
// Directed bench for e300_arty_devkit_chip with shortened UART and heartbeat dividers.
`timescale 1ns/1ps

module tb_e300_arty_devkit_chip;

    localparam int unsigned DIV = 4;
    localparam int unsigned BD  = 16;
    localparam int unsigned HB  = 50;

    logic       clk        = 1'b0;
    logic       cpu_rst_n  = 1'b0;
    logic       jtag_rst_n = 1'b0;
    logic       uart_tx;
    logic       boot_done;
    logic [3:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_banner [14] = '{8'h45, 8'h33, 8'h30, 8'h30, 8'h20, 8'h42, 8'h4F,
                                    8'h4F, 8'h54, 8'h20, 8'h4F, 8'h4B, 8'h0D, 8'h0A};

    e300_arty_devkit_chip #(
        .UART_DIV   (DIV),
        .BOOT_DELAY (BD),
        .HB_DIV     (HB)
    ) dut (
        .cpu_clock  (clk),
        .cpu_rst_n  (cpu_rst_n),
        .jtag_rst_n (jtag_rst_n),
        .uart_tx    (uart_tx),
        .boot_done  (boot_done),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        cpu_rst_n  = 1'b0;
        jtag_rst_n = 1'b0;
        tick(5);
        n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        n_tests++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", boot_done); end
        n_tests++; if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b expected 0000", led); end
        jtag_rst_n = 1'b1;
        tick(1);
        n_tests++; if (led[1] !== 1'b0) begin n_fail++; $display("FAIL jtag_led_1edge: got %b expected 0", led[1]); end
        tick(1);
        n_tests++; if (led[1] !== 1'b1) begin n_fail++; $display("FAIL jtag_led_2edge: got %b expected 1", led[1]); end
        tick(3);
        n_tests++; if ({uart_tx, boot_done, led} !== 6'b10_0010) begin
            n_fail++; $display("FAIL cpu_held: got tx/done/led %b expected 100010", {uart_tx, boot_done, led});
        end
    endtask

    task automatic test_boot_latency();
        cpu_rst_n = 1'b1;
        tick(BD + 1);
        n_tests++; if ({uart_tx, led[2]} !== 2'b10) begin
            n_fail++; $display("FAIL latency_early: got tx/busy %b expected 10", {uart_tx, led[2]});
        end
        tick(1);
        n_tests++; if ({uart_tx, led[2]} !== 2'b01) begin
            n_fail++; $display("FAIL latency_start: got tx/busy %b expected 01", {uart_tx, led[2]});
        end
    endtask

    // Entered on the first cycle of frame 0's start bit
    task automatic test_banner();
        logic [9:0] rx;
        logic [9:0] exp_frame;
        logic       exp_bit;
        int         bad;
        for (int f = 0; f < 14; f++) begin
            bad = 0;
            rx  = '0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < int'(DIV); c++) begin
                    if (b == 0)      exp_bit = 1'b0;
                    else if (b == 9) exp_bit = 1'b1;
                    else             exp_bit = exp_banner[f][b-1];
                    if (uart_tx !== exp_bit || led[2] !== 1'b1 || boot_done !== 1'b0) bad++;
                    if (c == int'(DIV) / 2) rx[b] = uart_tx;
                    tick(1);
                end
            end
            exp_frame = {1'b1, exp_banner[f], 1'b0};
            n_tests++; if (rx !== exp_frame) begin
                n_fail++; $display("FAIL frame_%0d: got %h expected %h", f, rx, exp_frame);
            end
            n_tests++; if (bad !== 0) begin
                n_fail++; $display("FAIL frame_%0d_timing: got %0d bad cycles expected 0", f, bad);
            end
        end
        n_tests++; if ({uart_tx, boot_done, led[3], led[2]} !== 4'b1110) begin
            n_fail++; $display("FAIL boot_done: got tx/done/led3/led2 %b expected 1110", {uart_tx, boot_done, led[3], led[2]});
        end
    endtask

    task automatic test_done_hold();
        int bad;
        bad = 0;
        repeat (200) begin
            if (uart_tx !== 1'b1 || boot_done !== 1'b1 || led[2] !== 1'b0) bad++;
            tick(1);
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL done_hold: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_heartbeat();
        logic prev;
        int   cnt;
        cpu_rst_n = 1'b0;
        #1;
        n_tests++; if ({boot_done, led[0], led[3]} !== 3'b000) begin
            n_fail++; $display("FAIL hb_reset: got done/led0/led3 %b expected 000", {boot_done, led[0], led[3]});
        end
        tick(2);
        cpu_rst_n = 1'b1;
        tick(2 + HB - 1);
        n_tests++; if (led[0] !== 1'b0) begin n_fail++; $display("FAIL hb_before: got %b expected 0", led[0]); end
        tick(1);
        n_tests++; if (led[0] !== 1'b1) begin n_fail++; $display("FAIL hb_first: got %b expected 1", led[0]); end
        for (int k = 0; k < 3; k++) begin
            prev = led[0];
            cnt  = 0;
            do begin
                tick(1);
                cnt++;
            end while (led[0] === prev && cnt < 2 * int'(HB));
            n_tests++; if (cnt !== int'(HB)) begin
                n_fail++; $display("FAIL hb_interval_%0d: got %0d cycles expected %0d", k, cnt, HB);
            end
        end
    endtask

    task automatic test_midreset();
        logic [9:0] rx;
        logic [9:0] exp_frame;
        cpu_rst_n = 1'b0;
        tick(2);
        cpu_rst_n = 1'b1;
        tick(BD + 2);
        tick(4 * 10 * DIV + 1);
        n_tests++; if ({uart_tx, led[2]} !== 2'b01) begin
            n_fail++; $display("FAIL mid_frame4_start: got tx/busy %b expected 01", {uart_tx, led[2]});
        end
        cpu_rst_n = 1'b0;
        #2;
        n_tests++; if ({uart_tx, led[2], led[1]} !== 3'b101) begin
            n_fail++; $display("FAIL mid_async: got tx/busy/led1 %b expected 101", {uart_tx, led[2], led[1]});
        end
        tick(3);
        cpu_rst_n = 1'b1;
        tick(BD + 1);
        n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL restart_early: got %b expected 1", uart_tx); end
        tick(1);
        n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL restart_start: got %b expected 0", uart_tx); end
        rx = '0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < int'(DIV); c++) begin
                if (c == int'(DIV) / 2) rx[b] = uart_tx;
                tick(1);
            end
        end
        exp_frame = {1'b1, 8'h45, 1'b0};
        n_tests++; if (rx !== exp_frame) begin
            n_fail++; $display("FAIL restart_frame: got %h expected %h", rx, exp_frame);
        end
    endtask

    // Entered on the first cycle of frame 1's start bit
    task automatic test_glitch();
        n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL glitch_pre: got %b expected 0", uart_tx); end
        jtag_rst_n = 1'b0;
        #2;
        jtag_rst_n = 1'b1;
        #1;
        n_tests++; if ({uart_tx, led[2], led[1]} !== 3'b100) begin
            n_fail++; $display("FAIL glitch_async: got tx/busy/led1 %b expected 100", {uart_tx, led[2], led[1]});
        end
        tick(1);
        n_tests++; if (led[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_led1_1edge: got %b expected 0", led[1]); end
        tick(1);
        n_tests++; if (led[1] !== 1'b1) begin n_fail++; $display("FAIL glitch_led1_2edge: got %b expected 1", led[1]); end
        tick(BD - 1);
        n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL glitch_restart_early: got %b expected 1", uart_tx); end
        tick(1);
        n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL glitch_restart_start: got %b expected 0", uart_tx); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_boot_latency();
        test_banner();
        test_done_hold();
        test_heartbeat();
        test_midreset();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
